// File: rtl/vscale_md_unit_pkg.sv
// Shared opcode and state encodings for the sequential RV32M multiply/divide unit.
package vscale_md_unit_pkg;

   localparam int MD_OP_WIDTH = 3;

   localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL    = 3'd0;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULH   = 3'd1;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULHSU = 3'd2;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULHU  = 3'd3;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV    = 3'd4;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIVU   = 3'd5;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM    = 3'd6;
   localparam logic [MD_OP_WIDTH-1:0] MD_OP_REMU   = 3'd7;

   typedef enum logic [2:0] {
      MD_STATE_IDLE    = 3'd0,
      MD_STATE_SETUP   = 3'd1,
      MD_STATE_COMPUTE = 3'd2,
      MD_STATE_FINAL   = 3'd3,
      MD_STATE_DONE    = 3'd4
   } md_state_e;

   // funct3 bit 2 separates the divide family from the multiply family.
   function automatic logic md_is_div(input logic [MD_OP_WIDTH-1:0] op);
      return op[2];
   endfunction

   function automatic logic md_in1_signed(input logic [MD_OP_WIDTH-1:0] op);
      return (op == MD_OP_MUL) || (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
             (op == MD_OP_DIV) || (op == MD_OP_REM);
   endfunction

   function automatic logic md_in2_signed(input logic [MD_OP_WIDTH-1:0] op);
      return (op == MD_OP_MUL) || (op == MD_OP_MULH) ||
             (op == MD_OP_DIV) || (op == MD_OP_REM);
   endfunction

endpackage

// File: rtl/vscale_md_unit.sv
// Multi-cycle RV32M multiply/divide: sign-magnitude operands, one bit per cycle
// (shift-add multiply, restoring divide), sign fix-up in a final cycle.
//
// state   | meaning
// IDLE    | ready for a request, operands latched on accept
// SETUP   | decode signedness, convert operands to magnitudes
// COMPUTE | XLEN iterations, counter runs XLEN-1 down to 0
// FINAL   | apply result signs, select word, register result
// DONE    | result valid, wait for resp_ready
module vscale_md_unit
   import vscale_md_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [MD_OP_WIDTH-1:0] req_op,
   input  logic [XLEN-1:0]        req_in_1,
   input  logic [XLEN-1:0]        req_in_2,
   input  logic                   kill,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [XLEN-1:0]        resp_result
);

   localparam int CW = $clog2(XLEN);

   md_state_e              state_q, state_d;
   logic [MD_OP_WIDTH-1:0] op_q, op_d;
   logic [XLEN-1:0]        in1_q, in1_d;
   logic [XLEN-1:0]        in2_q, in2_d;
   logic                   neg_result_q, neg_result_d;
   logic                   neg_rem_q, neg_rem_d;
   logic [CW-1:0]          counter_q, counter_d;
   logic [2*XLEN-1:0]      acc_q, acc_d;
   logic [XLEN-1:0]        result_q, result_d;

   logic                   sign1, sign2;
   logic [2*XLEN-1:0]      mul_step;
   logic [XLEN:0]          div_shifted;
   logic                   div_take;
   logic [XLEN-1:0]        div_rem_next;
   logic [2*XLEN-1:0]      div_step;
   logic [2*XLEN-1:0]      prod_signed;
   logic [XLEN-1:0]        quo_signed, rem_signed;
   logic [XLEN-1:0]        final_result;

   assign req_ready   = (state_q == MD_STATE_IDLE);
   assign resp_valid  = (state_q == MD_STATE_DONE);
   assign resp_result = result_q;

   always_comb begin
      sign1 = md_in1_signed(op_q) & in1_q[XLEN-1];
      sign2 = md_in2_signed(op_q) & in2_q[XLEN-1];

      // Multiplier consumed MSB first so the accumulator only ever shifts left.
      mul_step = {acc_q[2*XLEN-2:0], 1'b0} +
                 (in2_q[counter_q] ? {{XLEN{1'b0}}, in1_q} : {(2*XLEN){1'b0}});

      // Divide: remainder lives in acc[2X-1:X], quotient shifts into acc[X-1:0].
      div_shifted  = {acc_q[2*XLEN-1:XLEN], in1_q[counter_q]};
      div_take     = (div_shifted >= {1'b0, in2_q});
      div_rem_next = div_take ? XLEN'(div_shifted - {1'b0, in2_q}) : div_shifted[XLEN-1:0];
      div_step     = {div_rem_next, acc_q[XLEN-2:0], div_take};

      prod_signed = neg_result_q ? -acc_q : acc_q;
      // A zero divisor yields an all-ones quotient regardless of operand signs.
      quo_signed  = (neg_result_q && (in2_q != '0)) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_signed  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

      if (md_is_div(op_q)) begin
         final_result = op_q[1] ? rem_signed : quo_signed;
      end else begin
         final_result = (op_q == MD_OP_MUL) ? prod_signed[XLEN-1:0]
                                            : prod_signed[2*XLEN-1:XLEN];
      end
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      in1_d        = in1_q;
      in2_d        = in2_q;
      neg_result_d = neg_result_q;
      neg_rem_d    = neg_rem_q;
      counter_d    = counter_q;
      acc_d        = acc_q;
      result_d     = result_q;

      case (state_q)
         MD_STATE_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               in1_d   = req_in_1;
               in2_d   = req_in_2;
               state_d = MD_STATE_SETUP;
            end
         end
         MD_STATE_SETUP: begin
            if (kill) begin
               state_d = MD_STATE_IDLE;
            end else begin
               in1_d        = sign1 ? -in1_q : in1_q;
               in2_d        = sign2 ? -in2_q : in2_q;
               neg_result_d = sign1 ^ sign2;
               neg_rem_d    = sign1;
               acc_d        = '0;
               counter_d    = CW'(XLEN-1);
               state_d      = MD_STATE_COMPUTE;
            end
         end
         MD_STATE_COMPUTE: begin
            if (kill) begin
               state_d = MD_STATE_IDLE;
            end else begin
               acc_d     = md_is_div(op_q) ? div_step : mul_step;
               counter_d = counter_q - CW'(1);
               if (counter_q == '0) begin
                  state_d = MD_STATE_FINAL;
               end
            end
         end
         MD_STATE_FINAL: begin
            if (kill) begin
               state_d = MD_STATE_IDLE;
            end else begin
               result_d = final_result;
               state_d  = MD_STATE_DONE;
            end
         end
         MD_STATE_DONE: begin
            if (kill || resp_ready) begin
               state_d = MD_STATE_IDLE;
            end
         end
         default: state_d = MD_STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= MD_STATE_IDLE;
         op_q         <= '0;
         in1_q        <= '0;
         in2_q        <= '0;
         neg_result_q <= 1'b0;
         neg_rem_q    <= 1'b0;
         counter_q    <= '0;
         acc_q        <= '0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         in1_q        <= in1_d;
         in2_q        <= in2_d;
         neg_result_q <= neg_result_d;
         neg_rem_q    <= neg_rem_d;
         counter_q    <= counter_d;
         acc_q        <= acc_d;
         result_q     <= result_d;
      end
   end

endmodule
